// File: rtl/mem_stage_if.sv
// Bus between the execute stage and the memory-access stage of the multi-cycle core.
// The master drives step, access and control inputs; the slave returns the registered write-back controls.
interface mem_stage_if;
  logic [2:0]  state;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_addr;
  logic        branch_in;
  logic        reg_write_in;
  logic [4:0]  write_reg_in;
  logic [31:0] branch_addr_in;
  logic [31:0] reg_write_data_in;
  logic        branch_out;
  logic        reg_write_out;
  logic [4:0]  write_reg_out;
  logic [31:0] branch_addr_out;
  logic [31:0] reg_write_data_out;

  modport master (
    output state, mem_read, mem_write, mem_write_data, mem_addr,
           branch_in, reg_write_in, write_reg_in, branch_addr_in, reg_write_data_in,
    input  branch_out, reg_write_out, write_reg_out, branch_addr_out, reg_write_data_out
  );

  modport slave (
    input  state, mem_read, mem_write, mem_write_data, mem_addr,
           branch_in, reg_write_in, write_reg_in, branch_addr_in, reg_write_data_in,
    output branch_out, reg_write_out, write_reg_out, branch_addr_out, reg_write_data_out
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: one load or store from the word-addressed data memory,
// then registers the write-back and branch controls for the write-back stage.
module mem_stage #(
  parameter int unsigned    ADDR_BITS = 10,
  parameter logic [2:0]     MEM_STATE = 3'd3
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [31:0]          mem [DEPTH];
  logic [ADDR_BITS-1:0] idx;
  logic                 active;

  // Byte offset and bits above the array size are dropped, so addresses alias.
  assign idx    = bus.mem_addr[ADDR_BITS+1:2];
  assign active = (bus.state == MEM_STATE);

  // Kept free of reset so the array maps onto a single-port RAM.
  always_ff @(posedge clk) begin
    if (active && bus.mem_write && !rst)
      mem[idx] <= bus.mem_write_data;
  end

  // The read sees the pre-write word on a simultaneous load and store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.branch_out         <= 1'b0;
      bus.reg_write_out      <= 1'b0;
      bus.write_reg_out      <= '0;
      bus.branch_addr_out    <= '0;
      bus.reg_write_data_out <= '0;
    end else if (active) begin
      bus.branch_out         <= bus.branch_in;
      bus.reg_write_out      <= bus.reg_write_in;
      bus.write_reg_out      <= bus.write_reg_in;
      bus.branch_addr_out    <= bus.branch_addr_in;
      bus.reg_write_data_out <= bus.mem_read ? mem[idx] : bus.reg_write_data_in;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, pass-through, load/store, aliasing,
// read-old-data on simultaneous access, idle-state hold and asynchronous reset.
module tb_mem_stage;

  logic clk = 1'b1;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  mem_stage_if bus ();

  mem_stage #(
    .ADDR_BITS (10),
    .MEM_STATE (3'd3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input logic br, input logic rw,
                           input logic [4:0] wr, input logic [31:0] ba, input logic [31:0] d);
    check({tag, ".branch"},    {31'd0, bus.branch_out},    {31'd0, br});
    check({tag, ".reg_write"}, {31'd0, bus.reg_write_out}, {31'd0, rw});
    check({tag, ".write_reg"}, {27'd0, bus.write_reg_out}, {27'd0, wr});
    check({tag, ".br_addr"},   bus.branch_addr_out,        ba);
    check({tag, ".data"},      bus.reg_write_data_out,     d);
  endtask

  task automatic drive(input logic [2:0] st, input logic rd, input logic wr_en,
                       input logic [31:0] wdata, input logic [31:0] addr,
                       input logic br, input logic rw, input logic [4:0] wreg,
                       input logic [31:0] baddr, input logic [31:0] alu);
    bus.state             = st;
    bus.mem_read          = rd;
    bus.mem_write         = wr_en;
    bus.mem_write_data    = wdata;
    bus.mem_addr          = addr;
    bus.branch_in         = br;
    bus.reg_write_in      = rw;
    bus.write_reg_in      = wreg;
    bus.branch_addr_in    = baddr;
    bus.reg_write_data_in = alu;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(3'd0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 5'd0, '0, '0);
    #55 rst = 1'b0;
    #1;
    check_all("reset", 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);

    // Idle state: inputs present but nothing may change.
    drive(3'd0, 1'b0, 1'b1, 32'd555, 32'd1000, 1'b1, 1'b1, 5'd9, 32'd44, 32'd66);
    step();
    step();
    check_all("idle0", 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);

    // Store 1243 at byte 1000 with pass-through controls.
    drive(3'd3, 1'b0, 1'b1, 32'd1243, 32'd1000, 1'b1, 1'b1, 5'd1, 32'd32, 32'd31);
    step();
    check_all("store1", 1'b1, 1'b1, 5'd1, 32'd32, 32'd31);

    drive(3'd3, 1'b0, 1'b1, -32'sd123, 32'd156, 1'b0, 1'b1, 5'd2, 32'd0, -32'sd1000);
    step();
    check_all("store_neg", 1'b0, 1'b1, 5'd2, 32'd0, 32'hFFFF_FC18);

    drive(3'd3, 1'b1, 1'b0, '0, 32'd1000, 1'b0, 1'b1, 5'd3, 32'd8, 32'd7);
    step();
    check_all("load1000", 1'b0, 1'b1, 5'd3, 32'd8, 32'd1243);

    drive(3'd3, 1'b1, 1'b0, '0, 32'd156, 1'b1, 1'b0, 5'd31, 32'hDEAD_BEEF, 32'd7);
    step();
    check_all("load156", 1'b1, 1'b0, 5'd31, 32'hDEAD_BEEF, 32'hFFFF_FF85);

    drive(3'd3, 1'b0, 1'b1, 32'd1, 32'd1000, 1'b0, 1'b0, 5'd0, '0, 32'd5);
    step();
    check("store_one.data", bus.reg_write_data_out, 32'd5);
    drive(3'd3, 1'b1, 1'b0, '0, 32'd1000, 1'b0, 1'b0, 5'd0, '0, 32'd5);
    step();
    check("reload.data", bus.reg_write_data_out, 32'd1);

    // Load and store on the same edge return the old word.
    drive(3'd3, 1'b1, 1'b1, 32'd77, 32'd1000, 1'b0, 1'b1, 5'd4, '0, 32'd5);
    step();
    check("rmw_old.data", bus.reg_write_data_out, 32'd1);
    drive(3'd3, 1'b1, 1'b0, '0, 32'd1000, 1'b0, 1'b1, 5'd4, '0, 32'd5);
    step();
    check("rmw_new.data", bus.reg_write_data_out, 32'd77);

    // Aliasing: high bits and byte offset are ignored.
    drive(3'd3, 1'b1, 1'b0, '0, 32'd1000 + 32'h0000_1000, 1'b0, 1'b1, 5'd4, '0, 32'd5);
    step();
    check("alias_hi.data", bus.reg_write_data_out, 32'd77);
    drive(3'd3, 1'b1, 1'b0, '0, 32'd1003, 1'b0, 1'b1, 5'd4, '0, 32'd5);
    step();
    check("alias_lo.data", bus.reg_write_data_out, 32'd77);

    // Other state: outputs hold, store suppressed.
    drive(3'd1, 1'b0, 1'b1, 32'd999, 32'd1000, 1'b1, 1'b0, 5'd17, 32'd123, 32'd456);
    step();
    drive(3'd1, 1'b1, 1'b1, 32'd888, 32'd156, 1'b0, 1'b1, 5'd18, 32'd321, 32'd654);
    step();
    check_all("hold", 1'b0, 1'b1, 5'd4, 32'd0, 32'd77);
    drive(3'd3, 1'b1, 1'b0, '0, 32'd1000, 1'b1, 1'b1, 5'd10, 32'd100, 32'd0);
    step();
    check_all("no_store", 1'b1, 1'b1, 5'd10, 32'd100, 32'd77);
    drive(3'd3, 1'b1, 1'b0, '0, 32'd156, 1'b1, 1'b1, 5'd10, 32'd100, 32'd0);
    step();
    check("no_store156.data", bus.reg_write_data_out, 32'hFFFF_FF85);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    step();
    check_all("rst_hold", 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    #2 rst = 1'b0;
    drive(3'd3, 1'b1, 1'b0, '0, 32'd156, 1'b0, 1'b1, 5'd6, 32'd12, 32'd0);
    step();
    check_all("post_rst", 1'b0, 1'b1, 5'd6, 32'd12, 32'hFFFF_FF85);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
